// File: rtl/hazard_scoreboard_pkg.sv
// Shared uISA definitions: opcodes, register IDs, half-register index mapping.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_ID_W   = 5;
    localparam int unsigned OPC_W      = 6;
    localparam int unsigned NUM_HALVES = 16;
    localparam int unsigned NUM_FLAGS  = 8;
    localparam int unsigned SB_CNT_W   = 3;
    localparam int unsigned HALF_IDX_W = 4;

    // Opcodes
    localparam logic [OPC_W-1:0] NOP_op = 6'h00;
    localparam logic [OPC_W-1:0] ADD_op = 6'h01;
    localparam logic [OPC_W-1:0] LD_op  = 6'h10;
    localparam logic [OPC_W-1:0] IN_op  = 6'h14;
    localparam logic [OPC_W-1:0] MUL_op = 6'h20;

    // Register IDs: R0, sixteen 8-bit registers, six pairs
    localparam logic [REG_ID_W-1:0] rR0  = 5'd0;
    localparam logic [REG_ID_W-1:0] rA   = 5'd1;
    localparam logic [REG_ID_W-1:0] rF   = 5'd2;
    localparam logic [REG_ID_W-1:0] rB   = 5'd3;
    localparam logic [REG_ID_W-1:0] rC   = 5'd4;
    localparam logic [REG_ID_W-1:0] rD   = 5'd5;
    localparam logic [REG_ID_W-1:0] rE   = 5'd6;
    localparam logic [REG_ID_W-1:0] rH   = 5'd7;
    localparam logic [REG_ID_W-1:0] rL   = 5'd8;
    localparam logic [REG_ID_W-1:0] rT0  = 5'd9;
    localparam logic [REG_ID_W-1:0] rT1  = 5'd10;
    localparam logic [REG_ID_W-1:0] rT2  = 5'd11;
    localparam logic [REG_ID_W-1:0] rT3  = 5'd12;
    localparam logic [REG_ID_W-1:0] rU0  = 5'd13;
    localparam logic [REG_ID_W-1:0] rU1  = 5'd14;
    localparam logic [REG_ID_W-1:0] rU2  = 5'd15;
    localparam logic [REG_ID_W-1:0] rU3  = 5'd16;
    localparam logic [REG_ID_W-1:0] rAF  = 5'd17;
    localparam logic [REG_ID_W-1:0] rBC  = 5'd18;
    localparam logic [REG_ID_W-1:0] rDE  = 5'd19;
    localparam logic [REG_ID_W-1:0] rHL  = 5'd20;
    localparam logic [REG_ID_W-1:0] rT10 = 5'd21;
    localparam logic [REG_ID_W-1:0] rT32 = 5'd22;

    // Half-register indices (bit positions in the half masks)
    localparam logic [HALF_IDX_W-1:0] H_A  = 4'd0;
    localparam logic [HALF_IDX_W-1:0] H_F  = 4'd1;
    localparam logic [HALF_IDX_W-1:0] H_B  = 4'd2;
    localparam logic [HALF_IDX_W-1:0] H_C  = 4'd3;
    localparam logic [HALF_IDX_W-1:0] H_D  = 4'd4;
    localparam logic [HALF_IDX_W-1:0] H_E  = 4'd5;
    localparam logic [HALF_IDX_W-1:0] H_H  = 4'd6;
    localparam logic [HALF_IDX_W-1:0] H_L  = 4'd7;
    localparam logic [HALF_IDX_W-1:0] H_T0 = 4'd8;
    localparam logic [HALF_IDX_W-1:0] H_T1 = 4'd9;
    localparam logic [HALF_IDX_W-1:0] H_T2 = 4'd10;
    localparam logic [HALF_IDX_W-1:0] H_T3 = 4'd11;

    // Expanded operand footprint: half-registers plus flag bits
    typedef struct packed {
        logic [NUM_HALVES-1:0] halves;
        logic [NUM_FLAGS-1:0]  flags;
    } sb_mask_t;

    function automatic logic is_single(input logic [REG_ID_W-1:0] id);
        return (id >= rA) && (id <= rU3);
    endfunction

    function automatic logic is_pair(input logic [REG_ID_W-1:0] id);
        return (id >= rAF) && (id <= rT32);
    endfunction

    // 8-bit IDs are numbered in half-index order starting at 1
    function automatic logic [HALF_IDX_W-1:0] single_half(input logic [REG_ID_W-1:0] id);
        return HALF_IDX_W'(id - 5'd1);
    endfunction

    // Pair map: returns {high half index, low half index}
    function automatic logic [2*HALF_IDX_W-1:0] pair_halves(input logic [REG_ID_W-1:0] id);
        logic [2*HALF_IDX_W-1:0] hl;
        hl = '0;
        case (id)
            rAF:     hl = {H_A,  H_F};
            rBC:     hl = {H_B,  H_C};
            rDE:     hl = {H_D,  H_E};
            rHL:     hl = {H_H,  H_L};
            rT10:    hl = {H_T1, H_T0};
            rT32:    hl = {H_T3, H_T2};
            default: hl = '0;
        endcase
        return hl;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID/EXE hazard bus between the pipeline (master) and the scoreboard (slave).
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic                   flush;
    logic                   id_valid;
    logic [REG_ID_W-1:0]    id_rd0_id;
    logic [REG_ID_W-1:0]    id_rd1_id;
    logic [NUM_FLAGS-1:0]   id_fread;
    logic                   ex_valid;
    logic [OPC_W-1:0]       ex_opcode;
    logic [REG_ID_W-1:0]    ex_wr_id;
    logic [NUM_FLAGS-1:0]   ex_fmask;
    logic                   stall_clr;
    logic                   bubble;
    logic [NUM_HALVES-1:0]  pend_halves;
    logic [CNT_W-1:0]       stall_cnt;

    modport master (
        output flush, id_valid, id_rd0_id, id_rd1_id, id_fread,
               ex_valid, ex_opcode, ex_wr_id, ex_fmask, stall_clr,
        input  bubble, pend_halves, stall_cnt
    );

    modport slave (
        input  flush, id_valid, id_rd0_id, id_rd1_id, id_fread,
               ex_valid, ex_opcode, ex_wr_id, ex_fmask, stall_clr,
        output bubble, pend_halves, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// 3-bit pending-write counter: clear beats load beats decrement-to-zero.
module sb_counter
    import hazard_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic                i_load,
    input  logic [SB_CNT_W-1:0] i_load_val,
    output logic                o_nz
);

    logic [SB_CNT_W-1:0] r_cnt;

    // Load overwrites any residual count; otherwise count down and stop at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - SB_CNT_W'(1);
        end
    end

    assign o_nz = |r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit between ID and EXE: tracks long-latency writes per half/flag.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned LAT      = 2,
    parameter int unsigned MUL_LONG = 0,
    parameter int unsigned CNT_W    = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    hazard_scoreboard_if.slave hz
);

    // LAT=1 results forward straight out of EXE, so nothing is ever parked
    localparam logic                LOAD_ON  = (LAT > 1);
    localparam logic [SB_CNT_W-1:0] LOAD_VAL = SB_CNT_W'(LAT - 1);

    logic                  w_ex_long;
    logic                  w_load_en;
    sb_mask_t              w_src;
    sb_mask_t              w_dst;
    logic [NUM_HALVES-1:0] w_half_nz;
    logic [NUM_FLAGS-1:0]  w_flag_nz;
    logic                  w_half_hit;
    logic                  w_flag_hit;
    logic                  w_bubble;
    logic [CNT_W-1:0]      r_stall_cnt;

    function automatic logic [NUM_HALVES-1:0] expand_halves(input logic [REG_ID_W-1:0] id);
        logic [NUM_HALVES-1:0]   m;
        logic [2*HALF_IDX_W-1:0] hl;
        m  = '0;
        hl = pair_halves(id);
        if (is_single(id)) begin
            m[single_half(id)] = 1'b1;
        end else if (is_pair(id)) begin
            m[hl[2*HALF_IDX_W-1:HALF_IDX_W]] = 1'b1;
            m[hl[HALF_IDX_W-1:0]]            = 1'b1;
        end
        return m;
    endfunction

    function automatic logic covers_flags(input logic [REG_ID_W-1:0] id);
        return (id == rF) || (id == rAF);
    endfunction

    assign w_ex_long = hz.ex_valid &&
                       ((hz.ex_opcode == LD_op) || (hz.ex_opcode == IN_op) ||
                        ((MUL_LONG != 0) && (hz.ex_opcode == MUL_op)));
    assign w_load_en = LOAD_ON && w_ex_long;

    // Expand ID sources and the EXE destination into half/flag footprints
    always_comb begin
        w_src        = '0;
        w_dst        = '0;
        w_src.halves = expand_halves(hz.id_rd0_id) | expand_halves(hz.id_rd1_id);
        w_src.flags  = hz.id_fread;
        if (covers_flags(hz.id_rd0_id) || covers_flags(hz.id_rd1_id)) begin
            w_src.flags = '1;
        end
        if (w_ex_long) begin
            w_dst.halves = expand_halves(hz.ex_wr_id);
            w_dst.flags  = covers_flags(hz.ex_wr_id) ? '1 : hz.ex_fmask;
        end
    end

    // One counter per half-register
    for (genvar g = 0; g < NUM_HALVES; g++) begin : g_half
        sb_counter u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_clr      (hz.flush),
            .i_load     (w_load_en && w_dst.halves[g]),
            .i_load_val (LOAD_VAL),
            .o_nz       (w_half_nz[g])
        );
    end

    // One counter per flag bit
    for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_flag
        sb_counter u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_clr      (hz.flush),
            .i_load     (w_load_en && w_dst.flags[g]),
            .i_load_val (LOAD_VAL),
            .o_nz       (w_flag_nz[g])
        );
    end

    assign w_half_hit = |(w_src.halves & (w_dst.halves | w_half_nz));
    assign w_flag_hit = |(w_src.flags & (w_dst.flags | w_flag_nz));
    assign w_bubble   = hz.id_valid && !hz.flush && (w_half_hit || w_flag_hit);

    // Saturating stall-cycle counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (hz.stall_clr) begin
            r_stall_cnt <= '0;
        end else if (w_bubble && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign hz.bubble      = w_bubble;
    assign hz.pend_halves = w_half_nz;
    assign hz.stall_cnt   = r_stall_cnt;

endmodule
